// File: rtl/gs_ddram_pkg.sv
// Shared types and byte-lane helpers for the GS-to-DDR3 byte bridge.
package gs_ddram_pkg;

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

  localparam int LINE_BYTES = 8;
  localparam int TAG_W      = 18;

  function automatic logic [7:0] lane_sel(input logic [63:0] ln, input logic [2:0] lane);
    return ln[{lane, 3'b000} +: 8];
  endfunction

  function automatic logic [63:0] lane_merge(input logic [63:0] ln, input logic [2:0] lane,
                                             input logic [7:0] b);
    logic [63:0] r;
    r = ln;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/gs_ddram_bridge.sv
// Converts held Z80-style GS byte requests into single-beat 64-bit Avalon
// transactions, with a one-line write-through read cache.
module gs_ddram_bridge
  import gs_ddram_pkg::*;
#(
  parameter logic [28:0] DDR_BASE = 29'h0300_0000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [20:0] addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        rd,
  input  logic        we,
  output logic        ready,
  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE
);

  state_t             state, state_nx;
  logic [63:0]        line;
  logic [TAG_W-1:0]   tag;
  logic               valid;
  logic               drain;
  logic               done, done_we;
  logic [20:0]        done_addr;

  logic [TAG_W-1:0]   tag_in;
  logic [2:0]         lane;
  logic               hit, rd_hit, req_new;
  logic               latch, fill, wr_merge;

  assign tag_in  = addr[20:3];
  assign lane    = addr[2:0];
  assign hit     = valid & (tag == tag_in);
  assign rd_hit  = rd & ~we & hit;
  // A held request that already completed must not be reissued.
  assign req_new = (rd | we) & (~done | (addr != done_addr) | (we != done_we));

  assign dout           = lane_sel(line, lane);
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_ADDR     = DDR_BASE + {11'b0, tag_in};
  assign DDRAM_BE       = 8'b1 << lane;
  assign DDRAM_DIN      = {LINE_BYTES{din}};

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    DDRAM_RD = 1'b0;
    DDRAM_WE = 1'b0;
    ready    = 1'b0;
    latch    = 1'b0;
    fill     = 1'b0;
    wr_merge = 1'b0;
    case (state)
      IDLE: begin
        ready = ~(req_new & ~rd_hit);
        if (req_new) begin
          if (we)          state_nx = WR_REQ;
          else if (hit)    latch    = 1'b1;
          else if (!drain) state_nx = RD_REQ;
        end
      end
      RD_REQ: begin
        DDRAM_RD = 1'b1;
        if (!DDRAM_BUSY) state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        if (DDRAM_DOUT_READY) begin
          fill     = 1'b1;
          latch    = 1'b1;
          state_nx = IDLE;
        end
      end
      WR_REQ: begin
        DDRAM_WE = 1'b1;
        if (!DDRAM_BUSY) begin
          wr_merge = hit;
          latch    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      line      <= '0;
      tag       <= '0;
      valid     <= 1'b0;
      done      <= 1'b0;
      done_we   <= 1'b0;
      done_addr <= '0;
    end else begin
      if (!(rd | we)) done <= 1'b0;
      if (latch) begin
        done      <= 1'b1;
        done_addr <= addr;
        done_we   <= we;
      end
      if (fill) begin
        line  <= DDRAM_DOUT;
        tag   <= tag_in;
        valid <= 1'b1;
      end
      if (wr_merge) line <= lane_merge(line, lane, din);
    end
  end

  // drain survives reset: an accepted read still returns its beat, which must be swallowed.
  always_ff @(posedge clk_sys) begin
    if (state == RD_REQ && !DDRAM_BUSY) drain <= 1'b1;
    else if (DDRAM_DOUT_READY)          drain <= 1'b0;
  end

endmodule

// File: tb/tb_gs_ddram_bridge.sv
// Directed bench for gs_ddram_bridge: miss/hit, write-through, reset drain, BUSY stall.
module tb_gs_ddram_bridge;

  localparam logic [28:0] BASE = 29'h0300_0000;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [20:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        rd, we, ready;
  logic        DDRAM_BUSY;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT;
  logic        DDRAM_DOUT_READY;
  logic        DDRAM_RD;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;

  int n_cmp = 0, n_bad = 0;
  int rd_hi = 0, rd_acc = 0, we_hi = 0;
  int r0, a0, w0;

  gs_ddram_bridge #(.DDR_BASE(BASE)) dut (
    .clk_sys(clk_sys), .reset(reset), .addr(addr), .din(din), .dout(dout),
    .rd(rd), .we(we), .ready(ready),
    .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR),
    .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY), .DDRAM_RD(DDRAM_RD),
    .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE)
  );

  always #5 clk_sys = ~clk_sys;

  // Command-cycle monitor, sampled mid-cycle.
  always @(negedge clk_sys) begin
    if (DDRAM_RD) begin
      rd_hi++;
      if (!DDRAM_BUSY) rd_acc++;
    end
    if (DDRAM_WE) we_hi++;
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; addr = '0; din = '0; rd = 1'b0; we = 1'b0;
    DDRAM_BUSY = 1'b0; DDRAM_DOUT = '0; DDRAM_DOUT_READY = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_ready", ready, 1);
    check("rst_rd", DDRAM_RD, 0);
    check("rst_we", DDRAM_WE, 0);
    check("rst_dout", dout, 8'h00);
    check("burstcnt", DDRAM_BURSTCNT, 8'd1);

    // Read miss
    rd = 1'b1; addr = 21'h00010;
    #1;
    check("miss_ready0", ready, 0);
    check("miss_addr", DDRAM_ADDR, BASE + 29'd2);
    tick();
    check("miss_rd_cmd", DDRAM_RD, 1);
    check("miss_ready1", ready, 0);
    tick();
    check("miss_rd_off", DDRAM_RD, 0);
    check("miss_ready2", ready, 0);
    DDRAM_DOUT = 64'h0706050403020100; DDRAM_DOUT_READY = 1'b1;
    tick();
    DDRAM_DOUT_READY = 1'b0;
    #1;
    check("miss_ready_done", ready, 1);
    check("miss_dout", dout, 8'h00);
    check("miss_one_beat", rd_acc, 1);

    // Sequential hits with rd held
    for (int i = 3; i <= 7; i++) begin
      addr = 21'h00010 + 21'(i);
      #1;
      check("hit_ready", ready, 1);
      check("hit_dout", dout, 64'(i));
      tick();
    end
    check("hit_no_rd", rd_hi, 1);

    // Write-through hit with BUSY stall
    rd = 1'b0; we = 1'b1; addr = 21'h00012; din = 8'hA5; DDRAM_BUSY = 1'b1;
    #1;
    check("wr_ready0", ready, 0);
    check("wr_be", DDRAM_BE, 8'h04);
    check("wr_din", DDRAM_DIN, 64'hA5A5A5A5A5A5A5A5);
    w0 = we_hi;
    tick();
    check("wr_we_held", DDRAM_WE, 1);
    check("wr_rd_low", DDRAM_RD, 0);
    tick(); tick(); tick();
    DDRAM_BUSY = 1'b0;
    #1;
    check("wr_we_last", DDRAM_WE, 1);
    tick();
    #1;
    check("wr_ready_done", ready, 1);
    check("wr_we_cycles", we_hi - w0, 4);
    we = 1'b0; rd = 1'b1; addr = 21'h00012;
    #1;
    check("wt_hit_ready", ready, 1);
    check("wt_hit_dout", dout, 8'hA5);
    tick();

    // Write miss: no allocate
    rd = 1'b0; we = 1'b1; addr = 21'h40000; din = 8'h5A;
    #1;
    check("wm_addr", DDRAM_ADDR, BASE + 29'h8000);
    tick(); tick();
    #1;
    check("wm_ready", ready, 1);
    we = 1'b0; rd = 1'b1; addr = 21'h00011;
    #1;
    check("wm_still_hit", ready, 1);
    check("wm_dout", dout, 8'h01);
    check("wm_no_rd", rd_acc, 1);
    tick();

    // Reset in RD_WAIT, stale beat must be drained
    addr = 21'h00100;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("drn_ready0", ready, 0);
    check("drn_rd0", DDRAM_RD, 0);
    tick();
    check("drn_rd1", DDRAM_RD, 0);
    check("drn_ready1", ready, 0);
    DDRAM_DOUT = 64'hDEADBEEFDEADBEEF; DDRAM_DOUT_READY = 1'b1;
    tick();
    DDRAM_DOUT_READY = 1'b0;
    #1;
    check("drn_rd2", DDRAM_RD, 0);
    check("drn_ready2", ready, 0);
    tick();
    check("drn_refetch", DDRAM_RD, 1);
    check("drn_addr", DDRAM_ADDR, BASE + 29'd32);
    tick();
    DDRAM_DOUT = 64'h1716151413121110; DDRAM_DOUT_READY = 1'b1;
    tick();
    DDRAM_DOUT_READY = 1'b0;
    #1;
    check("drn_fill_ready", ready, 1);
    check("drn_fill_dout", dout, 8'h10);
    check("drn_beats", rd_acc, 3);

    // BUSY stall at the top of the address space
    addr = 21'h1FFFFF; DDRAM_BUSY = 1'b1;
    #1;
    check("wrap_addr", DDRAM_ADDR, BASE + 29'h3FFFF);
    check("wrap_be", DDRAM_BE, 8'h80);
    r0 = rd_hi; a0 = rd_acc;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("stall_cmd", {DDRAM_RD, DDRAM_ADDR}, {1'b1, BASE + 29'h3FFFF});
      tick();
    end
    DDRAM_BUSY = 1'b0;
    #1;
    check("stall_last", {DDRAM_RD, DDRAM_ADDR}, {1'b1, BASE + 29'h3FFFF});
    tick();
    check("stall_rd_off", DDRAM_RD, 0);
    check("stall_rd_cycles", rd_hi - r0, 6);
    check("stall_accepts", rd_acc - a0, 1);
    DDRAM_DOUT = 64'h8877665544332211; DDRAM_DOUT_READY = 1'b1;
    tick();
    DDRAM_DOUT_READY = 1'b0;
    #1;
    check("wrap_ready", ready, 1);
    check("wrap_dout", dout, 8'h88);
    addr = 21'h1FFFF8;
    #1;
    check("b2b_ready", ready, 1);
    check("b2b_dout", dout, 8'h11);
    tick();
    rd = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gs_ddram_bridge.md
Name: gs_ddram_bridge

Overview:
- Byte-wide bridge between the General Sound memory port of the tsconf core and the 64-bit DDR3 Avalon port.
- Sits directly downstream of the GS_ADDR/GS_DI/GS_DO/GS_RD/GS_WR/GS_WAIT signals. It converts Z80-style held byte requests into single-beat 64-bit DDR transactions.
- Keeps a one-line (8-byte) write-through read cache, so sequential GS fetches within one line complete with zero wait.

Parameters:
- DDR_BASE, 29'h0300_0000: DDR 64-bit word address of GS RAM byte 0.

Ports:
- clk_sys  in  1  single clock (the DDR-side memory clock); all logic on rising edge
- reset  in  1  synchronous, active-high
- addr  in  21  GS byte address
- din  in  8  write data
- dout  out  8  read data; valid while ready=1 and rd=1
- rd  in  1  read request, held by the requester until ready seen high
- we  in  1  write request, held likewise; rd and we are never both high (the design treats rd=we=1 as a write)
- ready  out  1  request complete / no request pending; GS_WAIT = ~ready
- DDRAM_BUSY  in  1  Avalon waitrequest
- DDRAM_BURSTCNT  out  8  constant 1
- DDRAM_ADDR  out  29  word address
- DDRAM_DOUT  in  64  read data
- DDRAM_DOUT_READY  in  1  read data valid
- DDRAM_RD  out  1  read command
- DDRAM_DIN  out  64  write data
- DDRAM_BE  out  8  byte enables
- DDRAM_WE  out  1  write command

Behaviour:
- Word address: DDRAM_ADDR = DDR_BASE + addr[20:3], computed in 29 bits with carry discarded.
- Byte lane: lane = addr[2:0]. DDRAM_BE = 8'b1 << lane. DDRAM_DIN = {8{din}}.
- Cache state: line[63:0], tag[17:0], valid.
  - hit = valid & (tag == addr[20:3]).
  - dout = line byte at lane (combinational mux).
- New request: req_new = (rd|we) & (no request completed since rd|we last rose, OR addr/we differ from the completed request's latched addr/we).
- ready = (state==IDLE) & ~(req_new & ~(rd & ~we & hit)). A read hit completes in the same cycle with zero wait.
- IDLE state:
  - Read hit: latch addr/we as completed; stay in IDLE.
  - Read miss, drain=0: go to RD_REQ.
  - Write: go to WR_REQ.
- RD_REQ:
  - DDRAM_RD=1, address held.
  - On ~DDRAM_BUSY: go to RD_WAIT and set drain=1.
- RD_WAIT:
  - On DDRAM_DOUT_READY: line <= DDRAM_DOUT, tag <= addr[20:3], valid <= 1, drain <= 0, latch completed, go to IDLE.
  - ready rises on the following cycle, i.e. minimum 3 cycles after the request if BUSY=0 and data returns the cycle after the command.
- WR_REQ:
  - DDRAM_WE=1 until ~DDRAM_BUSY.
  - If hit, replace the line byte at lane with din in the same cycle (write-through; no allocate on miss).
  - Latch completed, go to IDLE.
- Command timing: DDRAM_RD and DDRAM_WE are each high for exactly the cycles spent in their state, never both high. Address, BE and DIN are stable while the command is held against BUSY.
- Reset values: state=IDLE, valid=0, DDRAM_RD=0, DDRAM_WE=0, completed-latch cleared. ready=1 when no request is pending. dout is don't-care but defined as 8'h00.
- Reset mid-read: state goes to IDLE and valid=0, but drain is NOT cleared by reset.
  - While drain=1, a read miss waits in IDLE with ready=0.
  - The stale DDRAM_DOUT_READY clears drain and its data is discarded.
  - Writes are unaffected by drain.
- Reset during WR_REQ: the write is abandoned.
- Back-to-back requests: the requester changing addr while keeping rd high counts as a new request with no idle gap required.
- Address wrap: addr=21'h1FFFFF maps to DDR_BASE+18'h3FFFF, lane 7.

Decomposition:
- Package gs_ddram_pkg holds:
  - the state enum (IDLE, RD_REQ, RD_WAIT, WR_REQ);
  - LINE_BYTES=8, TAG_W=18;
  - a function for lane select/merge.
- No sub-module needed; the line buffer is registers, not RAM.

Test Plan:
- Read miss: reset, rd=1 addr=21'h00010, DDR returns 64'h0706050403020100 -> DDRAM_ADDR=DDR_BASE+2, one RD beat, ready low until data, dout=8'h00.
- Read hits: then addr=21'h00013..00017 with rd held -> no DDRAM_RD pulses, ready stays 1, dout=8'h03..8'h07.
- Write-through: we=1 addr=21'h00012 din=8'hA5 with BUSY high 3 cycles -> WE held 3+1 cycles, BE=8'h04, DIN=64'hA5A5…A5; subsequent read of 21'h00012 hits with dout=8'hA5.
- Write miss: we to 21'h40000 then read 21'h00011 -> still a hit, returning 8'h01 (no allocate).
- Reset mid-read: reset asserted in RD_WAIT, new read to 21'h00100 issued, stale DOUT_READY arrives -> stale data discarded, no DDRAM_RD until stale beat arrives, then a correct fill from DDR_BASE+32.
- BUSY stall: DDRAM_BUSY high 5 cycles in RD_REQ -> DDRAM_RD and DDRAM_ADDR stable for all 6 cycles, exactly one command accepted.
